// File: rtl/adder_tree_pkg.sv
// -----------------------------------------------------------------------------
// adder_tree_pkg
// Shared definitions for the adder-tree scheduler and related TDC resources:
//   - sched_state_e : scheduler enable/drain state machine encoding
//   - clog2_min1()  : ceil(log2(value)), never less than 1, used for ID and
//                     in-flight counter widths
// -----------------------------------------------------------------------------
package adder_tree_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

    // ceil(log2(value)) with a floor of 1 so a single requester still gets a 1-bit ID
    function automatic int clog2_min1(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if (int'(32'd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/adder_tree_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The search starts one past the pointer
// (the last winner) so the previous winner has the lowest priority.
// Ports:
//   req_i  [NUM_REQ]  request vector
//   ptr_i  [PTR_W]    index of the last granted requester
//   en_i              grant enable; 0 forces an all-zero grant
//   gnt_o  [NUM_REQ]  one-hot grant, or zero when nothing is requested/enabled
// -----------------------------------------------------------------------------
module rr_arbiter
    import adder_tree_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic             found_s;
    logic [PTR_W-1:0] idx_s;

    // Walk the requesters from ptr+1 around to ptr, first request wins
    always_comb begin
        gnt_o   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx_s = PTR_W'((int'(ptr_i) + i) % NUM_REQ);
            if (en_i && !found_s && req_i[idx_s]) begin
                gnt_o[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/adder_tree_sched.sv
// -----------------------------------------------------------------------------
// adder_tree_sched
// Shares one pipelined adder_tree among NUM_REQ requesters. At most one vector
// is issued per cycle (round robin), the requester ID follows the vector through
// a tag line matched to the tree latency, and each sum is returned with its ID.
// An IDLE/RUN/DRAIN machine lets the parent quiesce the tree.
//
// Optional feature macro: ADDER_TREE_SCHED_TAG_CHECK_EN
//   defined   : a tag-valid bit travels with each ID; any disagreement between
//               i_Tree_Valid and that bit sets the sticky o_Err
//   undefined : no tag-valid storage, o_Err tied to 0
//
// Ports:
//   i_Clk, i_Reset        clock, synchronous active-high reset
//   i_Enable              1 = grant requests, 0 = drain and go idle
//   i_Req_Valid/Data      per-requester valid and packed vector (req 0 in LSBs)
//   o_Req_Ready           combinational one-hot grant
//   o_Tree_In/Valid       registered issue towards the tree
//   i_Tree_Out/Valid      tree result
//   o_Res_Valid/Id/Data   registered result with requester ID
//   o_Idle                IDLE and nothing in flight
//   o_Err                 sticky tag/valid mismatch
// -----------------------------------------------------------------------------
module adder_tree_sched
    import adder_tree_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int NUM_OF_INS      = 5,
    parameter int WIDTH_PER_IN    = 16,
    parameter int WIDTH_FINAL_OUT = 19,
    parameter int TREE_LATENCY    = 3
) (
    input  logic                                       i_Clk,
    input  logic                                       i_Reset,
    input  logic                                       i_Enable,
    input  logic [NUM_REQ-1:0]                         i_Req_Valid,
    input  logic [NUM_REQ*NUM_OF_INS*WIDTH_PER_IN-1:0] i_Req_Data,
    output logic [NUM_REQ-1:0]                         o_Req_Ready,
    output logic [NUM_OF_INS*WIDTH_PER_IN-1:0]         o_Tree_In,
    output logic                                       o_Tree_Valid,
    input  logic [WIDTH_FINAL_OUT-1:0]                 i_Tree_Out,
    input  logic                                       i_Tree_Valid,
    output logic                                       o_Res_Valid,
    output logic [clog2_min1(NUM_REQ)-1:0]             o_Res_Id,
    output logic [WIDTH_FINAL_OUT-1:0]                 o_Res_Data,
    output logic                                       o_Idle,
    output logic                                       o_Err
);

    localparam int ID_W  = clog2_min1(NUM_REQ);
    localparam int CNT_W = clog2_min1(TREE_LATENCY + 2);
    localparam int VEC_W = NUM_OF_INS * WIDTH_PER_IN;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

    sched_state_e         state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q;
    logic [NUM_REQ-1:0]   gnt_s;
    logic                 issue_s;
    logic [ID_W-1:0]      gnt_idx_s;
    logic [VEC_W-1:0]     issue_vec_s;
    logic [VEC_W-1:0]     tree_in_q;
    logic                 tree_valid_q;
    logic [ID_W-1:0]      tree_id_q;
    logic [ID_W-1:0]      tag_id_q [TREE_LATENCY];
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 dec_s;
    logic                 res_valid_q;
    logic [ID_W-1:0]      res_id_q;
    logic [WIDTH_FINAL_OUT-1:0] res_data_q;
    logic                 idle_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (ID_W)
    ) u_arb (
        .req_i   (i_Req_Valid),
        .ptr_i   (rr_ptr_q),
        .en_i    ((state_q == ST_RUN) && i_Enable),
        .gnt_o   (gnt_s)
    );

    // Encode the one-hot grant and select the granted vector
    always_comb begin
        gnt_idx_s   = '0;
        issue_vec_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_idx_s   = gnt_idx_s | (gnt_s[i] ? ID_W'(i) : '0);
            issue_vec_s = issue_vec_s | (gnt_s[i] ? i_Req_Data[i*VEC_W +: VEC_W] : '0);
        end
        issue_s = |gnt_s;
    end

    // In-flight counter next value; a tree result with nothing in flight is ignored
    always_comb begin
        dec_s = i_Tree_Valid && (cnt_q != '0);
        case ({issue_s, dec_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Enable/drain state machine; drain completes on the cycle the last result returns
    always_comb begin
        case (state_q)
            ST_IDLE:  state_d = i_Enable ? ST_RUN : ST_IDLE;
            ST_RUN:   state_d = i_Enable ? ST_RUN : ST_DRAIN;
            ST_DRAIN: begin
                if (i_Enable) begin
                    state_d = ST_RUN;
                end else if (cnt_d == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, issue stage, tag line, counter and result registers
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= ID_W'(NUM_REQ - 1);
            tree_in_q    <= '0;
            tree_valid_q <= 1'b0;
            tree_id_q    <= '0;
            for (int k = 0; k < TREE_LATENCY; k++) begin
                tag_id_q[k] <= '0;
            end
            cnt_q        <= '0;
            res_valid_q  <= 1'b0;
            res_id_q     <= '0;
            res_data_q   <= '0;
            idle_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tree_valid_q <= issue_s;
            if (issue_s) begin
                rr_ptr_q  <= gnt_idx_s;
                tree_in_q <= issue_vec_s;
                tree_id_q <= gnt_idx_s;
            end
            // The issue-stage register plus TREE_LATENCY stages lines up with i_Tree_Valid
            tag_id_q[0] <= tree_id_q;
            for (int k = 1; k < TREE_LATENCY; k++) begin
                tag_id_q[k] <= tag_id_q[k-1];
            end
            cnt_q       <= cnt_d;
            res_valid_q <= dec_s;
            if (dec_s) begin
                res_id_q   <= tag_id_q[TREE_LATENCY-1];
                res_data_q <= i_Tree_Out;
            end
            idle_q <= (state_d == ST_IDLE) && (cnt_d == '0);
        end
    end

`ifdef ADDER_TREE_SCHED_TAG_CHECK_EN
    logic tag_v_q [TREE_LATENCY];
    logic err_q;

    // Tag-valid line mirrors the ID line; any disagreement with the tree valid is sticky
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            for (int k = 0; k < TREE_LATENCY; k++) begin
                tag_v_q[k] <= 1'b0;
            end
            err_q <= 1'b0;
        end else begin
            tag_v_q[0] <= tree_valid_q;
            for (int k = 1; k < TREE_LATENCY; k++) begin
                tag_v_q[k] <= tag_v_q[k-1];
            end
            err_q <= err_q | (i_Tree_Valid ^ tag_v_q[TREE_LATENCY-1]);
        end
    end

    assign o_Err = err_q;
`else
    assign o_Err = 1'b0;
`endif

    assign o_Req_Ready  = gnt_s;
    assign o_Tree_In    = tree_in_q;
    assign o_Tree_Valid = tree_valid_q;
    assign o_Res_Valid  = res_valid_q;
    assign o_Res_Id     = res_id_q;
    assign o_Res_Data   = res_data_q;
    assign o_Idle       = idle_q;

endmodule

// File: tb/tb_adder_tree_sched.sv
// -----------------------------------------------------------------------------
// tb_adder_tree_sched
// Drives randomized requests into adder_tree_sched, emulates the adder tree
// (sum of the input fields after TREE_LATENCY cycles) and compares every
// result against a scoreboard filled at issue time by a behavioural model.
// -----------------------------------------------------------------------------
module tb_adder_tree_sched;

    localparam int NUM_REQ         = 4;
    localparam int NUM_OF_INS      = 5;
    localparam int WIDTH_PER_IN    = 16;
    localparam int WIDTH_FINAL_OUT = 19;
    localparam int TREE_LATENCY    = 3;
    localparam int ID_W            = 2;
    localparam int VEC_W           = NUM_OF_INS * WIDTH_PER_IN;

    logic                               i_Clk = 1'b0;
    logic                               i_Reset;
    logic                               i_Enable;
    logic [NUM_REQ-1:0]                 i_Req_Valid;
    logic [NUM_REQ*VEC_W-1:0]           i_Req_Data;
    logic [NUM_REQ-1:0]                 o_Req_Ready;
    logic [VEC_W-1:0]                   o_Tree_In;
    logic                               o_Tree_Valid;
    logic [WIDTH_FINAL_OUT-1:0]         i_Tree_Out;
    logic                               i_Tree_Valid;
    logic                               o_Res_Valid;
    logic [ID_W-1:0]                    o_Res_Id;
    logic [WIDTH_FINAL_OUT-1:0]         o_Res_Data;
    logic                               o_Idle;
    logic                               o_Err;

    always #5 i_Clk = ~i_Clk;

    adder_tree_sched #(
        .NUM_REQ         (NUM_REQ),
        .NUM_OF_INS      (NUM_OF_INS),
        .WIDTH_PER_IN    (WIDTH_PER_IN),
        .WIDTH_FINAL_OUT (WIDTH_FINAL_OUT),
        .TREE_LATENCY    (TREE_LATENCY)
    ) dut (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .i_Enable     (i_Enable),
        .i_Req_Valid  (i_Req_Valid),
        .i_Req_Data   (i_Req_Data),
        .o_Req_Ready  (o_Req_Ready),
        .o_Tree_In    (o_Tree_In),
        .o_Tree_Valid (o_Tree_Valid),
        .i_Tree_Out   (i_Tree_Out),
        .i_Tree_Valid (i_Tree_Valid),
        .o_Res_Valid  (o_Res_Valid),
        .o_Res_Id     (o_Res_Id),
        .o_Res_Data   (o_Res_Data),
        .o_Idle       (o_Idle),
        .o_Err        (o_Err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge i_Clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- adder tree emulation ----------------
    logic                       tv_pipe [TREE_LATENCY];
    logic [WIDTH_FINAL_OUT-1:0] td_pipe [TREE_LATENCY];
    logic                       spur = 1'b0;

    function automatic logic [WIDTH_FINAL_OUT-1:0] tree_sum(input logic [VEC_W-1:0] v);
        logic [WIDTH_FINAL_OUT-1:0] s;
        s = '0;
        for (int k = 0; k < NUM_OF_INS; k++) s = s + WIDTH_FINAL_OUT'(v[k*WIDTH_PER_IN +: WIDTH_PER_IN]);
        return s;
    endfunction

    always @(posedge i_Clk) begin
        if (i_Reset) begin
            for (int k = 0; k < TREE_LATENCY; k++) begin
                tv_pipe[k] <= 1'b0;
                td_pipe[k] <= '0;
            end
        end else begin
            tv_pipe[0] <= o_Tree_Valid;
            td_pipe[0] <= tree_sum(o_Tree_In);
            for (int k = 1; k < TREE_LATENCY; k++) begin
                tv_pipe[k] <= tv_pipe[k-1];
                td_pipe[k] <= td_pipe[k-1];
            end
        end
    end

    assign i_Tree_Valid = tv_pipe[TREE_LATENCY-1] | spur;
    assign i_Tree_Out   = td_pipe[TREE_LATENCY-1];

    // ---------------- reference model ----------------
    typedef struct {
        int                         id;
        logic [WIDTH_FINAL_OUT-1:0] data;
        int                         cyc;
    } exp_t;

    exp_t sb[$];
    int   rets[$];          // cycles in which the tree will return an issued vector
    int   m_mode;           // 0 idle, 1 run, 2 drain
    int   m_ptr;
    bit   m_idle;
    bit   m_err;
    logic [WIDTH_PER_IN-1:0] vec_in [NUM_REQ][NUM_OF_INS];

    function automatic logic [WIDTH_FINAL_OUT-1:0] exp_sum(input int r);
        int s;
        s = 0;
        for (int k = 0; k < NUM_OF_INS; k++) s += int'(vec_in[r][k]);
        return WIDTH_FINAL_OUT'(s);
    endfunction

    // One clock cycle: check registered status, drive inputs, check grant, advance model
    task automatic cycle(input bit en, input logic [NUM_REQ-1:0] vld, input bit rnd, input bit sp);
        int c;
        int g;
        int nin;
        logic [NUM_REQ-1:0] exp_g;
        @(negedge i_Clk);
        c = cyc;
        check("idle", o_Idle, m_idle);
        check("err", o_Err, m_err);
        if (rnd) begin
            for (int r = 0; r < NUM_REQ; r++)
                for (int k = 0; k < NUM_OF_INS; k++)
                    vec_in[r][k] = WIDTH_PER_IN'($urandom);
        end
        for (int r = 0; r < NUM_REQ; r++)
            for (int k = 0; k < NUM_OF_INS; k++)
                i_Req_Data[(r*NUM_OF_INS+k)*WIDTH_PER_IN +: WIDTH_PER_IN] = vec_in[r][k];
        i_Enable    = en;
        i_Req_Valid = vld;
        spur        = sp;
        #1;
        g = -1;
        exp_g = '0;
        if (m_mode == 1 && en) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (g < 0 && vld[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
            end
        end
        if (g >= 0) exp_g[g] = 1'b1;
        check("ready", o_Req_Ready, exp_g);
        if (g >= 0) begin
            sb.push_back('{id: g, data: exp_sum(g), cyc: c + 2 + TREE_LATENCY});
            rets.push_back(c + 1 + TREE_LATENCY);
            m_ptr = g;
        end
`ifdef ADDER_TREE_SCHED_TAG_CHECK_EN
        if (sp && !(rets.size() > 0 && rets[0] == c)) m_err = 1'b1;
`endif
        while (rets.size() > 0 && rets[0] == c) void'(rets.pop_front());
        nin = rets.size();
        case (m_mode)
            0: if (en) m_mode = 1;
            1: if (!en) m_mode = 2;
            default: begin
                if (en) m_mode = 1;
                else if (nin == 0) m_mode = 0;
            end
        endcase
        m_idle = (m_mode == 0) && (nin == 0);
    endtask

    task automatic do_reset();
        @(negedge i_Clk);
        i_Reset     = 1'b1;
        i_Enable    = 1'b0;
        i_Req_Valid = '0;
        spur        = 1'b0;
        @(posedge i_Clk);
        #1;
        i_Reset = 1'b0;
        sb.delete();
        rets.delete();
        m_mode = 0;
        m_ptr  = NUM_REQ - 1;
        m_err  = 1'b0;
        @(negedge i_Clk);
        check("rst_ready", o_Req_Ready, '0);
        check("rst_tree_valid", o_Tree_Valid, 1'b0);
        check("rst_tree_in", o_Tree_In, '0);
        check("rst_res_valid", o_Res_Valid, 1'b0);
        check("rst_res_id", o_Res_Id, '0);
        check("rst_res_data", o_Res_Data, '0);
        check("rst_idle", o_Idle, 1'b0);
        check("rst_err", o_Err, 1'b0);
        m_idle = 1'b1;
    endtask

    // ---------------- result monitor ----------------
    exp_t mon_e;
    always @(negedge i_Clk) begin
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL res_missing: id %0d due cycle %0d not seen by cycle %0d", sb[0].id, sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
        if (o_Res_Valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL res_unexpected at cycle %0d: id %0d data %0h, nothing expected", cyc, o_Res_Id, o_Res_Data);
            end else begin
                mon_e = sb.pop_front();
                check("res_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("res_id", o_Res_Id, mon_e.id[ID_W-1:0]);
                check("res_data", o_Res_Data, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        i_Reset     = 1'b1;
        i_Enable    = 1'b0;
        i_Req_Valid = '0;
        i_Req_Data  = '0;
        for (int r = 0; r < NUM_REQ; r++)
            for (int k = 0; k < NUM_OF_INS; k++) vec_in[r][k] = '0;
        do_reset();
        repeat (2) cycle(1'b0, '0, 1'b0, 1'b0);

        // single request from requester 2 with inputs 1..5
        cycle(1'b1, '0, 1'b0, 1'b0);
        for (int k = 0; k < NUM_OF_INS; k++) vec_in[2][k] = WIDTH_PER_IN'(k + 1);
        cycle(1'b1, 4'b0100, 1'b0, 1'b0);
        check("single_ready", o_Req_Ready, 4'b0100);
        check("single_sum", 64'(exp_sum(2)), 64'(15));
        repeat (6) cycle(1'b1, '0, 1'b0, 1'b0);

        // full load, all requesters valid
        repeat (8) cycle(1'b1, 4'b1111, 1'b1, 1'b0);

        // drain with requests still pending
        repeat (3) cycle(1'b1, 4'b1111, 1'b1, 1'b0);
        cycle(1'b0, 4'b1111, 1'b1, 1'b0);
        check("drain_ready", o_Req_Ready, '0);
        repeat (8) cycle(1'b0, '0, 1'b0, 1'b0);

        // spurious tree valid with nothing in flight
        cycle(1'b0, '0, 1'b0, 1'b1);
        repeat (4) cycle(1'b0, '0, 1'b0, 1'b0);

        // randomized traffic with occasional enable drops
        for (int n = 0; n < 300; n++)
            cycle(($urandom_range(0, 9) != 0), NUM_REQ'($urandom), 1'b1, 1'b0);

        // reset with vectors in flight
        repeat (3) cycle(1'b1, 4'b1111, 1'b1, 1'b0);
        do_reset();
        repeat (6) cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 4'b1111, 1'b1, 1'b0);
        cycle(1'b1, 4'b1111, 1'b1, 1'b0);
        check("first_after_rst", o_Req_Ready, 4'b0001);
        repeat (6) cycle(1'b1, 4'b1111, 1'b1, 1'b0);

        // final drain
        repeat (12) cycle(1'b0, '0, 1'b0, 1'b0);
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
